pattern_match_dc: RTL and testbench

Parametrised serial pattern matcher with don't-care masking, the sequential successor to the enable-gated don't-care decoder in the pattern-matching lab. A 1-bit stream is shifted into an N-bit window. Each window is compared against a runtime-loaded pattern, and bit positions whose mask bit is clear are ignored. The block produces a registered match pulse and a saturating match counter, with overlapping and non-overlapping detection modes. It sits between the lab's stimulus source and the result checker.

---
 rtl/pattern_match_dc.sv | 92 +++++++++
 tb/tb_pattern_match_dc.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pattern_match_dc.sv
// pattern_match_dc: serial pattern matcher with per-bit don't-care masking.
// A 1-bit stream is shifted into an N-bit window, and each full window is
// compared against a runtime-loaded pattern. Only the bit positions whose
// mask bit is set take part in the comparison. Outputs are a registered
// single-cycle match pulse and a saturating match counter.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   cfg_load     load cfg_pattern/cfg_mask and restart detection (highest priority)
//   cfg_pattern  pattern; bit N-1 is the oldest bit received
//   cfg_mask     care mask; 1 = compare, 0 = don't care
//   overlap      1 = overlapping matches, 0 = window refills after each hit
//   en           accept din this cycle
//   din          serial data bit
//   window       current shift window; bit 0 is the newest bit
//   valid        window holds at least N accepted bits since the last restart
//   match        registered match pulse
//   match_count  saturating count of matches since reset or cfg_load
module pattern_match_dc #(
  parameter int unsigned N  = 4,
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cfg_load,
  input  logic [N-1:0]  cfg_pattern,
  input  logic [N-1:0]  cfg_mask,
  input  logic          overlap,
  input  logic          en,
  input  logic          din,
  output logic [N-1:0]  window,
  output logic          valid,
  output logic          match,
  output logic [CW-1:0] match_count
);

  localparam int unsigned FW = $clog2(N + 1);
  localparam logic [FW-1:0] FillFull = FW'(N);

  logic [N-1:0]  pat_q, msk_q, win_q;
  logic [FW-1:0] fill_q;
  logic          match_q;
  logic [CW-1:0] cnt_q;

  logic [N-1:0]  nwin;
  logic [FW-1:0] nfill;
  logic          hit;

  always_comb begin
    nwin  = {win_q[N-2:0], din};
    nfill = (fill_q == FillFull) ? fill_q : fill_q + FW'(1);
    // Masked-off positions are forced to agree, so only cared bits can miss.
    hit   = (nfill == FillFull) && (((nwin ^ pat_q) & msk_q) == '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat_q   <= '0;
      msk_q   <= '1;
      win_q   <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
      cnt_q   <= '0;
    end else if (cfg_load) begin
      // din is discarded here even when en is high.
      pat_q   <= cfg_pattern;
      msk_q   <= cfg_mask;
      win_q   <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
      cnt_q   <= '0;
    end else if (en) begin
      win_q   <= nwin;
      match_q <= hit;
      if (hit && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CW'(1);
      end
      // Non-overlapping mode restarts the fill count so the next match needs
      // N fresh bits; the window contents themselves are kept.
      fill_q  <= (hit && !overlap) ? '0 : nfill;
    end else begin
      match_q <= 1'b0;
    end
  end

  assign window      = win_q;
  assign valid       = (fill_q == FillFull);
  assign match       = match_q;
  assign match_count = cnt_q;

endmodule

// File: tb/tb_pattern_match_dc.sv
module tb_pattern_match_dc;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         cfg_load = 1'b0;
  logic [N-1:0] cfg_pattern = '0;
  logic [N-1:0] cfg_mask = '1;
  logic         overlap = 1'b0;
  logic         en = 1'b0;
  logic         din = 1'b0;

  logic [N-1:0] window_a, window_b;
  logic         valid_a, valid_b, match_a, match_b;
  logic [7:0]   count_a;
  logic [1:0]   count_b;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: pattern, mask, accepted-bit history since the last
  // restart, bits accumulated toward the next full window, and counters.
  int unsigned m_pat, m_msk;
  bit          m_hist[$];
  int          m_since;
  bit          m_match;
  int unsigned m_cnt8, m_cnt2;

  always #5 clk = ~clk;

  pattern_match_dc #(.N(N), .CW(8)) dut_a (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_mask(cfg_mask), .overlap(overlap), .en(en), .din(din),
    .window(window_a), .valid(valid_a), .match(match_a), .match_count(count_a)
  );

  pattern_match_dc #(.N(N), .CW(2)) dut_b (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_mask(cfg_mask), .overlap(overlap), .en(en), .din(din),
    .window(window_b), .valid(valid_b), .match(match_b), .match_count(count_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Last N accepted bits, oldest in the high position, zero-filled.
  function automatic int unsigned model_window();
    int unsigned w = 0;
    foreach (m_hist[i]) w = ((w * 2) + m_hist[i]) % (1 << N);
    return w;
  endfunction

  function automatic bit model_hit();
    int unsigned w = model_window();
    for (int i = 0; i < N; i++) begin
      if (((m_msk >> i) & 1) != 0 && ((w >> i) & 1) != ((m_pat >> i) & 1)) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_clear(input int unsigned pat, input int unsigned msk);
    m_pat = pat; m_msk = msk;
    m_hist.delete();
    m_since = 0; m_match = 0; m_cnt8 = 0; m_cnt2 = 0;
  endtask

  task automatic check_all();
    check("window_a", 32'(window_a), model_window());
    check("window_b", 32'(window_b), model_window());
    check("valid_a", 32'(valid_a), 32'(m_since == N));
    check("valid_b", 32'(valid_b), 32'(m_since == N));
    check("match_a", 32'(match_a), 32'(m_match));
    check("match_b", 32'(match_b), 32'(m_match));
    check("count_a", 32'(count_a), m_cnt8);
    check("count_b", 32'(count_b), m_cnt2);
  endtask

  // One clock: drive on negedge, update model at posedge, sample 1 later.
  task automatic cycle(input bit ld, input bit e, input bit d, input bit ov);
    @(negedge clk);
    cfg_load = ld; en = e; din = d; overlap = ov;
    @(posedge clk);
    if (ld) begin
      model_clear(32'(cfg_pattern), 32'(cfg_mask));
    end else if (e) begin
      m_hist.push_back(d);
      if (m_hist.size() > N) void'(m_hist.pop_front());
      if (m_since < N) m_since++;
      m_match = (m_since == N) && model_hit();
      if (m_match) begin
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3) m_cnt2++;
        if (!ov) m_since = 0;
      end
    end else begin
      m_match = 0;
    end
    #1;
    check_all();
  endtask

  task automatic load(input logic [N-1:0] pat, input logic [N-1:0] msk, input bit e, input bit d);
    @(negedge clk);
    cfg_pattern = pat; cfg_mask = msk;
    cycle(1'b1, e, d, overlap);
  endtask

  task automatic feed(input logic [31:0] bits, input int len, input bit ov);
    for (int i = len - 1; i >= 0; i--) cycle(1'b0, 1'b1, bits[i], ov);
  endtask

  // Reset pulse asserted between clock edges; outputs must clear at once.
  task automatic async_reset();
    @(negedge clk);
    cfg_load = 1'b0; en = 1'b0;
    #2 reset = 1'b0;
    #1;
    model_clear(0, (1 << N) - 1);
    check("rst_window", 32'(window_a), 32'd0);
    check("rst_valid", 32'(valid_a), 32'd0);
    check("rst_count", 32'(count_a), 32'd0);
    check_all();
    @(negedge clk);
    #2 reset = 1'b1;
  endtask

  initial begin
    model_clear(0, (1 << N) - 1);
    #3;
    check_all();
    #20 reset = 1'b1;

    // Overlapping stream 1011011: hits after bits 4 and 7.
    load(4'b1011, 4'b1111, 1'b0, 1'b0);
    feed(32'b1011011, 7, 1'b1);
    check("ovl_count", 32'(count_a), 32'd2);

    // Same stream non-overlapping: one hit, window 1011 at the end, no match.
    load(4'b1011, 4'b1111, 1'b0, 1'b0);
    feed(32'b1011011, 7, 1'b0);
    check("novl_count", 32'(count_a), 32'd1);
    check("novl_window", 32'(window_a), 32'b1011);
    check("novl_match", 32'(match_a), 32'd0);

    // Don't-care positions: 1001 and 1111 hit, 0110 does not.
    load(4'b1001, 4'b1001, 1'b0, 1'b0);
    feed(32'b100111110110, 12, 1'b0);
    check("dc_count", 32'(count_a), 32'd2);

    // Idle gaps keep the sequence contiguous.
    load(4'b1011, 4'b1111, 1'b0, 1'b0);
    feed(32'b10, 2, 1'b1);
    repeat (3) cycle(1'b0, 1'b0, 1'b1, 1'b1);
    feed(32'b11, 2, 1'b1);
    check("gap_match", 32'(match_a), 32'd1);
    // cfg_load with en=1 discards din.
    load(4'b1011, 4'b1111, 1'b1, 1'b1);
    check("ld_window", 32'(window_a), 32'd0);
    check("ld_count", 32'(count_a), 32'd0);

    // All don't care, overlapping: match from bit 4 on; CW=2 saturates at 3.
    load(4'b0000, 4'b0000, 1'b0, 1'b0);
    feed(32'b10110010, 8, 1'b1);
    check("sat_count_b", 32'(count_b), 32'd3);
    check("sat_count_a", 32'(count_a), 32'd5);

    // Mid-stream reset restores pattern 0000 / mask 1111.
    load(4'b1011, 4'b1111, 1'b0, 1'b0);
    feed(32'b101, 3, 1'b1);
    async_reset();
    feed(32'b1011, 4, 1'b1);
    check("rst_nomatch", 32'(match_a), 32'd0);
    feed(32'b0000, 4, 1'b1);
    check("rst_zmatch", 32'(match_a), 32'd1);

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 199) == 0) begin
        async_reset();
      end else if ($urandom_range(0, 29) == 0) begin
        load(N'($urandom), ($urandom_range(0, 3) == 0) ? N'($urandom) : '1,
             1'($urandom), 1'($urandom));
      end else begin
        cycle(1'b0, $urandom_range(0, 9) < 7, 1'($urandom), 1'($urandom));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
